// File: rtl/div32_iter_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] DIV_OVF_DIVIDEND  = 32'h8000_0000;
    localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] quotient;
        logic [WIDTH-1:0] remainder;
        logic             div_by_zero;
    } div_res_t;

    // Magnitude of a two's complement operand, pass-through when unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/div32_iter_if.sv
// Start/valid request and result bundle between the core and the divider.
interface div32_iter_if;
    import div_pkg::*;

    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i,
        input  busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i,
        output busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/div32_iter_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] sum;
    logic           ge;

    // A set shifted-out bit means the partial remainder already exceeds any divisor.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        sum      = {1'b0, rem_sh[WIDTH-1:0]} + {1'b0, ~divisor} + (WIDTH+1)'(1);
        ge       = rem_sh[WIDTH] | sum[WIDTH];
        rem_next = ge ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div32_iter.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
module div32_iter
    import div_pkg::*;
(
    input logic         clk_i,
    input logic         rst_ni,
    div32_iter_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    div_res_t         res_q, res_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             accept_c, zero_c, ovf_c;

    assign accept_c = ((state_q == IDLE) || (state_q == DONE)) && bus.start_i;
    assign zero_c   = (bus.divisor_i == '0);
    assign ovf_c    = bus.signed_i && (bus.dividend_i == DIV_OVF_DIVIDEND) && (bus.divisor_i == '1);

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_c) state_d = (zero_c || ovf_c) ? DONE : CALC;
                else          state_d = IDLE;
            end
            CALC:    if (cnt_q == '0) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        valid_d   = 1'b0;
        busy_d    = (state_d == CALC) || (state_d == FIXUP);
        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    if (zero_c) begin
                        res_d.quotient    = DIV_ZERO_QUOTIENT;
                        res_d.remainder   = bus.dividend_i;
                        res_d.div_by_zero = 1'b1;
                        valid_d           = 1'b1;
                    end else if (ovf_c) begin
                        res_d.quotient    = DIV_OVF_DIVIDEND;
                        res_d.remainder   = '0;
                        res_d.div_by_zero = 1'b0;
                        valid_d           = 1'b1;
                    end else begin
                        rem_d     = '0;
                        quo_d     = abs_val(bus.dividend_i, bus.signed_i);
                        dvs_d     = abs_val(bus.divisor_i, bus.signed_i);
                        neg_quo_d = bus.signed_i && (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
                        neg_rem_d = bus.signed_i && bus.dividend_i[WIDTH-1];
                        cnt_d     = CNT_W'(WIDTH - 1);
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            FIXUP: begin
                res_d.quotient    = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
                res_d.remainder   = neg_rem_q ? WIDTH'(-rem_q) : rem_q;
                res_d.div_by_zero = 1'b0;
                valid_d           = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.valid_o       = valid_q;
    assign bus.quotient_o    = res_q.quotient;
    assign bus.remainder_o   = res_q.remainder;
    assign bus.div_by_zero_o = res_q.div_by_zero;

endmodule

// File: tb/tb_div32_iter.sv
// Directed and randomized checks of div32_iter against an arithmetic reference.
module tb_div32_iter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;
    int   busy_n;
    int   gap;
    logic [31:0] a, b, eq, er;
    logic        s, edz;
    int          mode;

    div32_iter_if bus();

    div32_iter dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, RISC-V rules for divide by zero.
    function automatic void ref_div(input logic sg, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sx, sy;
        if (y == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = x;
            dz = 1'b1;
        end else begin
            sx = sg ? longint'($signed(x)) : longint'(x);
            sy = sg ? longint'($signed(y)) : longint'(y);
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
            dz = 1'b0;
        end
    endfunction

    // Count negedges until valid_o, bounded.
    task automatic wait_valid(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.busy_o) nb++;
            if (bus.valid_o) break;
        end
    endtask

    task automatic run_op(input logic sg, input logic [31:0] x, input logic [31:0] y,
                          output int n, output int nb);
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.signed_i   = sg;
        bus.dividend_i = x;
        bus.divisor_i  = y;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_valid(n, nb);
    endtask

    task automatic op_check(input string tag, input logic sg, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] q, input logic [31:0] r, input logic dz, input int elat);
        int n, nb;
        run_op(sg, x, y, n, nb);
        check32({tag, "_lat"}, 32'(n), 32'(elat));
        check32({tag, "_quo"}, bus.quotient_o, q);
        check32({tag, "_rem"}, bus.remainder_o, r);
        check32({tag, "_dbz"}, {31'd0, bus.div_by_zero_o}, {31'd0, dz});
        check32({tag, "_busy"}, 32'(nb), (elat == 1) ? 32'd0 : 32'd33);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        rst_n          = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check32("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check32("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check32("rst_quo", bus.quotient_o, 32'd0);
        check32("rst_rem", bus.remainder_o, 32'd0);
        check32("rst_dbz", {31'd0, bus.div_by_zero_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        op_check("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        @(negedge clk);
        check32("valid_pulse", {31'd0, bus.valid_o}, 32'd0);
        check32("quo_held", bus.quotient_o, 32'd14);

        op_check("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
        op_check("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
        op_check("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
        op_check("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1);
        op_check("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

        // start held high: second request accepted in DONE
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        @(posedge clk);
        #1;
        wait_valid(lat, busy_n);
        check32("b2b_first_lat", 32'(lat), 32'd34);
        check32("b2b_first_quo", bus.quotient_o, 32'd14);
        bus.dividend_i = 32'hFFFF_FFFF;
        bus.divisor_i  = 32'd1;
        wait_valid(gap, busy_n);
        bus.start_i = 1'b0;
        check32("b2b_gap", 32'(gap), 32'd34);
        check32("b2b_quo", bus.quotient_o, 32'hFFFF_FFFF);
        check32("b2b_rem", bus.remainder_o, 32'd0);
        @(negedge clk);
        check32("b2b_idle_valid", {31'd0, bus.valid_o}, 32'd0);

        // start pulse during CALC must be ignored
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd10;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd5;
        bus.divisor_i  = 32'd5;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_valid(lat, busy_n);
        check32("calc_start_lat", 32'(lat + 4), 32'd34);
        check32("calc_start_quo", bus.quotient_o, 32'd100);
        check32("calc_start_rem", bus.remainder_o, 32'd0);

        // asynchronous reset mid-CALC clears everything
        op_check("pre_rst_by0", 1'b0, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF, 32'h0000_0055, 1'b1, 1);
        @(posedge clk);
        #1;
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'hDEAD_BEEF;
        bus.divisor_i  = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check32("mid_busy", {31'd0, bus.busy_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check32("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        check32("arst_valid", {31'd0, bus.valid_o}, 32'd0);
        check32("arst_quo", bus.quotient_o, 32'd0);
        check32("arst_rem", bus.remainder_o, 32'd0);
        check32("arst_dbz", {31'd0, bus.div_by_zero_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op_check("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        // randomized operations against the reference
        for (int i = 0; i < 24; i++) begin
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            mode = int'($urandom_range(0, 7));
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            ref_div(s, a, b, eq, er, edz);
            op_check($sformatf("rnd%0d", i), s, a, b, eq, er, edz,
                     ((b == 32'd0) || (s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) ? 1 : 34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div32_iter.md
# div32_iter

Iterative 32-bit integer divider for the RV32M datapath: the subtract-direction counterpart of the ripple adder chain. It performs one restoring shift-subtract step per clock, using an adder with inverted subtrahend and carry-in 1, plus sign pre/post-correction. It sits beside the ALU and returns quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics. A start/valid handshake stalls the core while the block is busy.

## Interface
- WIDTH, 32, operand width; only 32 is verified.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only when busy_o=0.
- signed_i  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- dividend_i  in  WIDTH  dividend, sampled with start_i.
- divisor_i  in  WIDTH  divisor, sampled with start_i.
- busy_o  out  1  high in CALC and FIXUP.
- valid_o  out  1  one-cycle pulse; results valid in that cycle and held afterwards.
- quotient_o  out  WIDTH  quotient, held until the next accepted start.
- remainder_o  out  WIDTH  remainder, held until the next accepted start.
- div_by_zero_o  out  1  set with valid_o when divisor was 0, held with results.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE with start_i=1: latch operands.
  - If divisor=0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero_o=1.
  - Else, if signed_i and dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE with quotient = 0x80000000, remainder = 0.
  - Else: go to CALC.
  - On entry to CALC, load |dividend| and |divisor| (absolute values only when signed_i), record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), clear the partial remainder, and set the step counter to WIDTH-1.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Compute diff = rem_shifted − divisor as a WIDTH+1-bit subtraction (rem_shifted + ~divisor + 1).
  - If diff is non-negative: rem = diff, quo LSB = 1. Else: keep rem_shifted, quo LSB = 0.
  - After the step with counter=0, go to FIXUP; otherwise decrement the counter.
- FIXUP: negate quotient if sign_q, negate remainder if sign_r (signed only), register outputs, go to DONE.
- DONE: valid_o=1 for this single cycle. Leave to IDLE unless start_i=1, in which case accept the new request (back-to-back operation).
- start_i in CALC/FIXUP is ignored. There is no abort.
- Reset (any time, including mid-CALC): state=IDLE; all outputs 0, i.e. busy_o, valid_o, quotient_o, remainder_o and div_by_zero_o are all 0. The in-flight operation is discarded.
- Remainder sign follows the dividend. Quotient truncates toward zero.

## Timing
- Start accepted at edge k. Normal path: CALC covers edges k+1..k+WIDTH, FIXUP ends at edge k+WIDTH+1, valid_o is high in the cycle after edge k+WIDTH+1.
  - Latency is 34 cycles for WIDTH=32.
- Special cases (divide by zero, signed overflow): valid_o is high in the cycle after edge k, so latency is 1.
- busy_o is high from the cycle after edge k until FIXUP completes. It is low in IDLE and DONE.
- Outputs are registered, with no combinational input-to-output path.

## Structure
- Package div_pkg holds:
  - the state enum (div_state_t: IDLE, CALC, FIXUP, DONE);
  - localparam DIV_OVF_DIVIDEND = 32'h8000_0000;
  - the divide-by-zero quotient constant.
- Sub-module div_step: a combinational single restoring step.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Internally it is a WIDTH+1-bit adder with inverted b and carry-in 1. The top-level instantiates it once.

## Test plan
- DIVU 100/7, start pulse -> valid_o exactly 34 cycles later; quotient=14, remainder=2, busy_o high for 33 cycles.
- DIV −100/7 (0xFFFFFF9C, 7) -> quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). DIV 100/−7 -> quotient=−14, remainder=2.
- Divide by zero: DIVU 0x12345678/0 -> valid_o 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero_o=1.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, latency 1. The same operands with DIVU -> quotient=0, remainder=0x80000000 after 34 cycles.
- start_i held high throughout: second operation (0xFFFFFFFF/1 unsigned) accepted in DONE, valid pulses 34 cycles apart. start_i pulses during CALC are ignored and results are unchanged.
- rst_ni dropped mid-CALC (cycle 10) -> all outputs 0 immediately (asynchronous). After release, a fresh DIVU 9/3 -> quotient=3, remainder=0.
